// File: rtl/pdpm_rx_parser.sv
// pDPM receive parser: pulls a memory command out of each Ethernet frame on an
// 8-bit AXI-S stream and forwards write payload on a second AXI-S stream.
module pdpm_rx_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A35000001,
    parameter logic [15:0] PDPM_ETYPE = 16'h88B5,
    parameter int          CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             glbl_rst,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_op,
    output logic [31:0]      cmd_addr,
    output logic [15:0]      cmd_len,
    output logic [47:0]      cmd_src_mac,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             err_short,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_dropped
);
    typedef enum logic [1:0] {HDR, CMD, PAYLOAD, DROP} state_t;

    state_t           state_q;
    logic [4:0]       idx_q;
    logic [39:0]      dst_q;
    logic [7:0]       etype_hi_q;
    logic             op_q;
    logic [15:0]      len_q;
    logic [31:0]      addr_q;
    logic [47:0]      src_q;
    logic             last20_q;
    logic [15:0]      rem_q;
    logic             err_q;
    logic [CNT_W-1:0] ok_q, ok_d, drop_q, drop_d;

    logic s_fire, cmd_fire, hdr_err, dst_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Header checks look at the byte currently on the bus, so a bad field is
    // caught in the same cycle it arrives.
    always_comb begin
        dst_bad = ({dst_q, s_axis_tdata} != LOCAL_MAC) && ({dst_q, s_axis_tdata} != {48{1'b1}});
        hdr_err = ((idx_q == 5'd5) && dst_bad)
               || ((idx_q == 5'd13) && ({etype_hi_q, s_axis_tdata} != PDPM_ETYPE))
               || ((idx_q == 5'd14) && (s_axis_tdata != 8'h01) && (s_axis_tdata != 8'h02));
        ok_d    = sat_inc(ok_q);
        drop_d  = sat_inc(drop_q);
    end

    always_comb begin
        case (state_q)
            HDR, DROP: s_axis_tready = ~glbl_rst;
            PAYLOAD:   s_axis_tready = m_axis_tready & ~glbl_rst;
            default:   s_axis_tready = 1'b0;
        endcase
    end

    assign s_fire         = s_axis_tvalid & s_axis_tready;
    assign cmd_valid      = (state_q == CMD);
    assign cmd_fire       = cmd_valid & cmd_ready;
    assign m_axis_tvalid  = (state_q == PAYLOAD) & s_axis_tvalid;
    assign m_axis_tdata   = (state_q == PAYLOAD) ? s_axis_tdata : 8'h00;
    assign m_axis_tlast   = (state_q == PAYLOAD) & ((rem_q == 16'd1) | s_axis_tlast);
    // A write whose frame ends on the last header byte has no payload at all.
    assign err_short      = err_q | (cmd_fire & last20_q & op_q & (len_q != 16'd0));
    assign cmd_op         = op_q;
    assign cmd_addr       = addr_q;
    assign cmd_len        = len_q;
    assign cmd_src_mac    = src_q;
    assign frames_ok      = ok_q;
    assign frames_dropped = drop_q;

    always_ff @(posedge clk_in or posedge glbl_rst) begin
        if (glbl_rst) begin
            state_q    <= HDR;
            idx_q      <= '0;
            dst_q      <= '0;
            etype_hi_q <= '0;
            op_q       <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            last20_q   <= 1'b0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            ok_q       <= '0;
            drop_q     <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                HDR: if (s_fire) begin
                    idx_q <= idx_q + 5'd1;
                    if (idx_q <= 5'd4) dst_q <= {dst_q[31:0], s_axis_tdata};
                    if (idx_q >= 5'd6 && idx_q <= 5'd11) src_q <= {src_q[39:0], s_axis_tdata};
                    if (idx_q == 5'd12) etype_hi_q <= s_axis_tdata;
                    if (idx_q == 5'd14) op_q <= (s_axis_tdata == 8'h02);
                    if (idx_q == 5'd15 || idx_q == 5'd16) len_q <= {len_q[7:0], s_axis_tdata};
                    if (idx_q >= 5'd17) addr_q <= {addr_q[23:0], s_axis_tdata};
                    if (idx_q == 5'd20) begin
                        idx_q    <= '0;
                        last20_q <= s_axis_tlast;
                        state_q  <= CMD;
                    end else if (s_axis_tlast || hdr_err) begin
                        idx_q   <= '0;
                        drop_q  <= drop_d;
                        state_q <= s_axis_tlast ? HDR : DROP;
                    end
                end
                CMD: if (cmd_ready) begin
                    ok_q <= ok_d;
                    if (last20_q) begin
                        state_q <= HDR;
                    end else if (!op_q || len_q == 16'd0) begin
                        state_q <= DROP;
                    end else begin
                        rem_q   <= len_q;
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: if (s_fire) begin
                    rem_q <= rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_q <= s_axis_tlast ? HDR : DROP;
                    end else if (s_axis_tlast) begin
                        err_q   <= 1'b1;
                        state_q <= HDR;
                    end
                end
                DROP: if (s_fire && s_axis_tlast) state_q <= HDR;
                default: state_q <= HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_pdpm_rx_parser.sv
// Bench for pdpm_rx_parser: directed and random frames checked against a
// frame-level reference model of commands, payload beats and counters.
module tb_pdpm_rx_parser;
    localparam logic [47:0] LMAC  = 48'h000A35000001;
    localparam logic [15:0] ETYPE = 16'h88B5;
    localparam logic [47:0] SRC   = 48'h020000ABCDEF;

    logic        clk_in = 1'b0, glbl_rst = 1'b1;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic        cmd_valid, cmd_ready = 1'b0, cmd_op;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [47:0] cmd_src_mac;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
    logic        err_short;
    logic [15:0] frames_ok, frames_dropped;

    pdpm_rx_parser dut (
        .clk_in(clk_in), .glbl_rst(glbl_rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_src_mac(cmd_src_mac),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .err_short(err_short), .frames_ok(frames_ok), .frames_dropped(frames_dropped)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        op;
        logic [31:0] addr;
        logic [15:0] len;
        logic [47:0] src;
    } cmd_t;

    int   checks = 0, errors = 0;
    int   cmd_delay = 0, mready_mode = 0, cwait = 0;
    int   stall_cyc = 0, cmd_tready_bad = 0, err_cnt = 0;
    int   exp_err = 0, exp_ok = 0, exp_drop = 0;
    bit   gaps = 1'b0;
    cmd_t got_cmd[$], exp_cmd[$];
    logic [8:0] got_beat[$], exp_beat[$];
    logic [7:0] frm[$];

    // Memory-side responders
    always @(posedge clk_in) begin
        #1;
        if (glbl_rst) begin
            cmd_ready = 1'b0;
            cwait     = 0;
        end else if (cmd_valid && !cmd_ready) begin
            if (cwait >= cmd_delay) cmd_ready = 1'b1;
            else cwait++;
        end else begin
            cmd_ready = 1'b0;
            cwait     = 0;
        end
        case (mready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk_in) begin
        if (!glbl_rst) begin
            if (cmd_valid && cmd_ready) got_cmd.push_back(cmd_t'({cmd_op, cmd_addr, cmd_len, cmd_src_mac}));
            if (cmd_valid && !cmd_ready) stall_cyc++;
            if (cmd_valid && s_axis_tready) cmd_tready_bad++;
            if (m_axis_tvalid && m_axis_tready) got_beat.push_back({m_axis_tlast, m_axis_tdata});
            if (err_short) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input logic [7:0] op, input logic [15:0] len, input logic [31:0] addr,
                         input int npay);
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        frm.push_back(op);
        frm.push_back(len[15:8]);
        frm.push_back(len[7:0]);
        for (int i = 3; i >= 0; i--) frm.push_back(addr[i*8 +: 8]);
        for (int i = 0; i < npay; i++) frm.push_back(8'($urandom));
    endtask

    // Frame-level expectation: one drop, or one command plus min(payload,len) beats.
    task automatic model();
        int n;
        int m;
        int k;
        logic [47:0] dst, src;
        logic [15:0] et, len;
        logic [31:0] addr;
        logic [7:0]  op;
        n = frm.size();
        if (n < 21) begin
            exp_drop++;
            return;
        end
        dst  = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        src  = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
        et   = {frm[12], frm[13]};
        op   = frm[14];
        len  = {frm[15], frm[16]};
        addr = {frm[17], frm[18], frm[19], frm[20]};
        if ((dst != LMAC && dst != 48'hFFFFFFFFFFFF) || et != ETYPE || (op != 8'h01 && op != 8'h02)) begin
            exp_drop++;
            return;
        end
        exp_ok++;
        exp_cmd.push_back(cmd_t'({op == 8'h02, addr, len, src}));
        if (op == 8'h02) begin
            m = n - 21;
            k = (m < int'(len)) ? m : int'(len);
            for (int i = 0; i < k; i++) exp_beat.push_back({i == k - 1, frm[21 + i]});
            if (m < int'(len)) exp_err++;
        end
    endtask

    task automatic send_frame(input int cut);
        int n;
        int waited;
        n = (cut > 0) ? cut : frm.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk_in);
                #1;
            end
            s_axis_tdata  = frm[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (cut == 0) && (i == n - 1);
            waited = 0;
            forever begin
                @(negedge clk_in);
                if (s_axis_tready) break;
                waited++;
                if (waited > 300) break;
            end
            if (waited > 300) begin
                errors++;
                $error("FAIL hs_timeout observed=stalled expected=accept byte %0d", i);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            @(posedge clk_in);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic verify(input string tag);
        int nc;
        int nb;
        check({tag, "_ncmd"}, got_cmd.size(), exp_cmd.size());
        nc = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
        for (int i = 0; i < nc; i++) check({tag, "_cmd"}, got_cmd[i], exp_cmd[i]);
        check({tag, "_nbeat"}, got_beat.size(), exp_beat.size());
        nb = (got_beat.size() < exp_beat.size()) ? got_beat.size() : exp_beat.size();
        for (int i = 0; i < nb; i++) check({tag, "_beat"}, got_beat[i], exp_beat[i]);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_ok"}, frames_ok, exp_ok);
        check({tag, "_drop"}, frames_dropped, exp_drop);
        got_cmd.delete();
        exp_cmd.delete();
        got_beat.delete();
        exp_beat.delete();
        err_cnt = 0;
        exp_err = 0;
    endtask

    task automatic run_frame(input string tag);
        stall_cyc = 0;
        model();
        send_frame(0);
        repeat (cmd_delay + 8) @(posedge clk_in);
        #1;
        verify(tag);
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_err_short", err_short, 0);
        check("rst_cmd_fields", {cmd_op, cmd_addr, cmd_len, cmd_src_mac}, 0);
        check("rst_counters", {frames_ok, frames_dropped}, 0);
        glbl_rst = 1'b0;
        @(posedge clk_in);
        #1;
        check("idle_s_tready", s_axis_tready, 1);

        build(LMAC, SRC, ETYPE, 8'h01, 16'h0040, 32'h00001000, 0);
        run_frame("read_basic");

        build(LMAC, SRC, ETYPE, 8'h02, 16'd4, 32'h00002000, 0);
        frm.push_back(8'hAA); frm.push_back(8'hBB); frm.push_back(8'hCC); frm.push_back(8'hDD);
        cmd_delay = 5;
        run_frame("write_delay");
        check("write_delay_stall", stall_cyc, 5);
        check("cmd_s_tready_low", cmd_tready_bad, 0);
        cmd_delay = 0;

        build(LMAC, SRC, ETYPE, 8'h02, 16'd4, 32'h00003000, 6);
        run_frame("write_excess");
        build(LMAC, SRC, ETYPE, 8'h01, 16'd8, 32'h00003004, 0);
        run_frame("after_excess");

        build(LMAC, SRC, ETYPE, 8'h02, 16'd8, 32'h00004000, 3);
        run_frame("write_short");

        build(48'h020000000099, SRC, ETYPE, 8'h01, 16'd4, 32'h0, 0);
        run_frame("bad_dst");
        build(LMAC, SRC, 16'h0800, 8'h01, 16'd4, 32'h0, 0);
        run_frame("bad_etype");
        check("drop_count_two", frames_dropped, 2);

        mready_mode = 1;
        build(LMAC, SRC, ETYPE, 8'h02, 16'd16, 32'h00005000, 16);
        run_frame("toggle16");
        mready_mode = 0;

        build(48'hFFFFFFFFFFFF, SRC, ETYPE, 8'h01, 16'd2, 32'h00006000, 0);
        run_frame("bcast_read");
        build(LMAC, SRC, ETYPE, 8'h03, 16'd2, 32'h0, 4);
        run_frame("bad_op");
        build(LMAC, SRC, ETYPE, 8'h01, 16'd2, 32'h0, 0);
        frm = frm[0:11];
        run_frame("short_hdr");
        build(LMAC, SRC, ETYPE, 8'h02, 16'd4, 32'h00007000, 0);
        run_frame("write_nopay");
        build(LMAC, SRC, ETYPE, 8'h02, 16'd0, 32'h00008000, 3);
        run_frame("write_len0");

        gaps = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int sel;
            logic [47:0] dst;
            logic [15:0] et;
            logic [7:0]  op;
            sel = $urandom_range(0, 9);
            dst = (sel < 7) ? LMAC : (sel == 7) ? 48'hFFFFFFFFFFFF : {16'h0200, 32'($urandom)};
            et  = ($urandom_range(0, 9) < 9) ? ETYPE : 16'($urandom);
            sel = $urandom_range(0, 9);
            op  = (sel < 5) ? 8'h02 : (sel < 9) ? 8'h01 : 8'($urandom);
            build(dst, {16'h0200, 32'($urandom)}, et, op, 16'($urandom_range(0, 20)),
                  32'($urandom), $urandom_range(0, 24));
            if ($urandom_range(0, 9) == 0) frm = frm[0:$urandom_range(0, 19)];
            cmd_delay   = $urandom_range(0, 3);
            mready_mode = $urandom_range(0, 2);
            run_frame("rand");
        end
        gaps        = 1'b0;
        cmd_delay   = 0;
        mready_mode = 0;

        build(LMAC, SRC, ETYPE, 8'h02, 16'd4, 32'h00009000, 4);
        send_frame(9);
        glbl_rst = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("midrst_counters", {frames_ok, frames_dropped}, 0);
        check("midrst_cmd_valid", cmd_valid, 0);
        glbl_rst = 1'b0;
        exp_ok   = 0;
        exp_drop = 0;
        got_cmd.delete();
        got_beat.delete();
        err_cnt = 0;
        @(posedge clk_in);
        #1;
        build(LMAC, SRC, ETYPE, 8'h02, 16'd5, 32'h0000A000, 5);
        run_frame("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
